// File: rtl/my_postproc_if.sv
// BRAM port bundle between the post-processing stage (master) and the shared result BRAM (slave).
interface my_postproc_if #(
  parameter int unsigned BRAM_ADDR_WIDTH = 32,
  parameter int unsigned BRAM_DATA_WIDTH = 32,
  parameter int unsigned BRAM_WE_WIDTH   = 4
);
  logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR;
  logic [BRAM_DATA_WIDTH-1:0] BRAM_WRDATA;
  logic [BRAM_WE_WIDTH-1:0]   BRAM_WE;
  logic [BRAM_DATA_WIDTH-1:0] BRAM_RDDATA;

  modport master (
    output BRAM_ADDR,
    output BRAM_WRDATA,
    output BRAM_WE,
    input  BRAM_RDDATA
  );

  modport slave (
    input  BRAM_ADDR,
    input  BRAM_WRDATA,
    input  BRAM_WE,
    output BRAM_RDDATA
  );
endinterface

// File: rtl/my_postproc.sv
// Post-processing stage: for each accumulator, add bias, saturate, arithmetic shift, optional ReLU,
// and write the result back to the shared BRAM. One element every five cycles.
module my_postproc #(
  parameter int unsigned BRAM_ADDR_WIDTH = 32,
  parameter int unsigned BRAM_DATA_WIDTH = 32,
  parameter int unsigned BRAM_WE_WIDTH   = 4
) (
  input  logic        S_AXI_ACLK,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] num_output,
  input  logic [31:0] bias_base,
  input  logic [31:0] out_base,
  input  logic [4:0]  shift,
  input  logic        relu_en,
  output logic        busy,
  output logic        done,
  my_postproc_if.master bram
);

  localparam int unsigned DW = BRAM_DATA_WIDTH;
  localparam int unsigned AW = BRAM_ADDR_WIDTH;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRdAcc   = 3'd1;
  localparam logic [2:0] StRdBias  = 3'd2;
  localparam logic [2:0] StCapBias = 3'd3;
  localparam logic [2:0] StCalc    = 3'd4;
  localparam logic [2:0] StWr      = 3'd5;
  localparam logic [2:0] StDone    = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [31:0]   idx_q, idx_d;
  logic [31:0]   n_q;
  logic [AW-1:0] bias_base_q;
  logic [AW-1:0] out_base_q;
  logic [4:0]    shift_q;
  logic          relu_q;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] bias_q;
  logic [DW-1:0] res_q;
  logic [DW-1:0] res_d;

  logic          start_job;
  logic [AW-1:0] elem_off;
  logic [DW:0]   sum;
  logic [DW-1:0] sat;
  logic [DW-1:0] sh;

  assign start_job = (state_q == StIdle) && start;
  assign elem_off  = AW'({idx_q, 2'b00});

  // One extra bit holds the exact sum; disagreeing top bits mean overflow.
  always_comb begin
    sum = {acc_q[DW-1], acc_q} + {bias_q[DW-1], bias_q};
    if (sum[DW] != sum[DW-1]) begin
      sat = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      sat = sum[DW-1:0];
    end
    sh    = $signed(sat) >>> shift_q;
    res_d = (relu_q && sh[DW-1]) ? '0 : sh;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = '0;
          state_d = (num_output == 32'd0) ? StDone : StRdAcc;
        end
      end
      StRdAcc:   state_d = StRdBias;
      StRdBias:  state_d = StCapBias;
      StCapBias: state_d = StCalc;
      StCalc:    state_d = StWr;
      StWr: begin
        if (idx_q == n_q - 32'd1) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 32'd1;
          state_d = StRdAcc;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      n_q         <= '0;
      bias_base_q <= '0;
      out_base_q  <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      acc_q       <= '0;
      bias_q      <= '0;
      res_q       <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (start_job) begin
        n_q         <= num_output;
        bias_base_q <= AW'(bias_base);
        out_base_q  <= AW'(out_base);
        shift_q     <= shift;
        relu_q      <= relu_en;
      end
      // Read data lags its address by one cycle.
      if (state_q == StRdBias)  acc_q  <= bram.BRAM_RDDATA;
      if (state_q == StCapBias) bias_q <= bram.BRAM_RDDATA;
      if (state_q == StCalc)    res_q  <= res_d;
    end
  end

  // BRAM outputs come only from registered state so inputs never glitch the port.
  always_comb begin
    bram.BRAM_ADDR   = '0;
    bram.BRAM_WRDATA = '0;
    bram.BRAM_WE     = '0;
    case (state_q)
      StRdAcc:   bram.BRAM_ADDR = elem_off;
      StRdBias:  bram.BRAM_ADDR = bias_base_q + elem_off;
      StCapBias: bram.BRAM_ADDR = bias_base_q + elem_off;
      StWr: begin
        bram.BRAM_ADDR   = out_base_q + elem_off;
        bram.BRAM_WRDATA = res_q;
        bram.BRAM_WE     = {BRAM_WE_WIDTH{1'b1}};
      end
      default: ;
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_my_postproc.sv
// Scoreboard bench for my_postproc: jobs push expected writes/done cycles, a negedge monitor checks.
module tb_my_postproc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] num_output;
  logic [31:0] bias_base;
  logic [31:0] out_base;
  logic [4:0]  shift;
  logic        relu_en;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  my_postproc_if bram_if ();

  my_postproc dut (
    .S_AXI_ACLK (clk),
    .reset      (reset),
    .start      (start),
    .num_output (num_output),
    .bias_base  (bias_base),
    .out_base   (out_base),
    .shift      (shift),
    .relu_en    (relu_en),
    .busy       (busy),
    .done       (done),
    .bram       (bram_if)
  );

  // BRAM model: one-cycle read latency, read-before-write.
  bit [31:0] mem [bit [31:0]];
  always @(posedge clk) begin
    bram_if.BRAM_RDDATA <= mem.exists(bram_if.BRAM_ADDR) ? mem[bram_if.BRAM_ADDR] : 32'h0;
    if (bram_if.BRAM_WE == 4'hF) mem[bram_if.BRAM_ADDR] = bram_if.BRAM_WRDATA;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          t;
  } wr_t;

  wr_t         wq[$];
  int          dq[$];
  logic [31:0] pend[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          n_wr = 0;
  int          job_t0 = 0;
  int          job_end = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_busy;
      wr_t  w;
      exp_busy = (cyc > job_t0) && (cyc <= job_end);
      chk("busy", busy, exp_busy);
      if (!exp_busy) chk("idle_addr", bram_if.BRAM_ADDR, 32'h0);
      if (bram_if.BRAM_WE != 4'h0) begin
        n_wr++;
        chk("we_full", bram_if.BRAM_WE, 4'hF);
        if (wq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %h data %h, required no write (cycle %0d)",
                   bram_if.BRAM_ADDR, bram_if.BRAM_WRDATA, cyc);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", bram_if.BRAM_ADDR, w.addr);
          chk("wr_data", bram_if.BRAM_WRDATA, w.data);
          chk("wr_cycle", cyc, w.t);
        end
      end else begin
        chk("wrdata_no_we", bram_if.BRAM_WRDATA, 32'h0);
      end
      if (done) begin
        if (dq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, required 0 (cycle %0d)", cyc);
        end else begin
          chk("done_cycle", cyc, dq.pop_front());
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Pulses start for one cycle; expected writes come from pend[] in element order.
  task automatic run_job(input int n, input logic [31:0] bb, input logic [31:0] ob,
                         input int sh, input bit relu, input bit exp_done);
    @(negedge clk);
    num_output = n;
    bias_base  = bb;
    out_base   = ob;
    shift      = sh[4:0];
    relu_en    = relu;
    start      = 1'b1;
    job_t0     = cyc;
    job_end    = cyc + 5 * n + 1;
    foreach (pend[k]) wq.push_back('{ob + 32'(4 * k), pend[k], cyc + 5 * k + 5});
    if (exp_done) dq.push_back(cyc + 5 * n + 1);
    pend.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    int wr_before;
    reset      = 1'b1;
    start      = 1'b0;
    num_output = '0;
    bias_base  = '0;
    out_base   = '0;
    shift      = '0;
    relu_en    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", bram_if.BRAM_ADDR, 32'h0);
    chk("rst_we", bram_if.BRAM_WE, 4'h0);
    chk("rst_wrdata", bram_if.BRAM_WRDATA, 32'h0);
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single element: (100 - 30) >>> 1 = 35
    mem[32'h0] = 32'd100;
    mem[32'h400] = 32'hFFFF_FFE2;
    pend = '{32'd35};
    run_job(1, 32'h400, 32'h100, 1, 1'b0, 1'b1);
    wait_until(job_end);
    repeat (2) @(negedge clk);
    chk("t1_mem", mem[32'h100], 32'd35);

    // ReLU and shift
    mem[32'h0] = 32'hFFFF_FFF8;
    mem[32'h4] = 32'd7;
    mem[32'h8] = 32'd256;
    mem[32'h400] = 32'd0;
    mem[32'h404] = 32'd0;
    mem[32'h408] = 32'd0;
    pend = '{32'd0, 32'd1, 32'd64};
    run_job(3, 32'h400, 32'h100, 2, 1'b1, 1'b1);
    wait_until(job_end);
    repeat (2) @(negedge clk);

    // Saturation, without then with ReLU
    mem[32'h0] = 32'h7FFF_FFF0;
    mem[32'h4] = 32'h8000_0000;
    mem[32'h400] = 32'h20;
    mem[32'h404] = 32'hFFFF_FFFF;
    pend = '{32'h7FFF_FFFF, 32'h8000_0000};
    run_job(2, 32'h400, 32'h200, 0, 1'b0, 1'b1);
    wait_until(job_end);
    repeat (2) @(negedge clk);
    pend = '{32'h7FFF_FFFF, 32'h0};
    run_job(2, 32'h400, 32'h200, 0, 1'b1, 1'b1);
    wait_until(job_end);
    repeat (2) @(negedge clk);

    // In-place, then back-to-back second job on the updated words
    mem[32'h0] = 32'd10;
    mem[32'h4] = 32'hFFFF_FFFF;
    mem[32'h8] = 32'd1000;
    mem[32'hC] = 32'hFFFF_FFCE;
    for (int k = 0; k < 4; k++) mem[32'h400 + 32'(4 * k)] = 32'd1;
    pend = '{32'd11, 32'd0, 32'd1001, 32'hFFFF_FFCF};
    run_job(4, 32'h400, 32'h0, 0, 1'b0, 1'b1);
    wait_until(job_end);
    pend = '{32'd12, 32'd1, 32'd1002, 32'hFFFF_FFD0};
    run_job(4, 32'h400, 32'h0, 0, 1'b0, 1'b1);
    wait_until(job_end);
    repeat (2) @(negedge clk);
    chk("inplace_mem3", mem[32'hC], 32'hFFFF_FFD0);

    // n == 0: done in cycle 1, no writes
    wr_before = n_wr;
    run_job(0, 32'h400, 32'h100, 0, 1'b0, 1'b1);
    wait_until(job_end);
    repeat (2) @(negedge clk);
    chk("n0_writes", 32'(n_wr - wr_before), 32'd0);

    // start while busy is ignored; input changes after start have no effect
    mem[32'h0] = 32'd40;
    mem[32'h4] = 32'hFFFF_FFD8;
    mem[32'h400] = 32'd2;
    mem[32'h404] = 32'd2;
    wr_before = n_wr;
    pend = '{32'd5, 32'hFFFF_FFFB};
    run_job(2, 32'h400, 32'h300, 3, 1'b0, 1'b1);
    wait_until(job_t0 + 3);
    start      = 1'b1;
    num_output = 32'd9;
    out_base   = 32'h700;
    shift      = 5'd0;
    @(negedge clk);
    start = 1'b0;
    wait_until(job_end);
    repeat (3) @(negedge clk);
    chk("busy_start_writes", 32'(n_wr - wr_before), 32'd2);

    // Reset in cycle 7 of an n=3 job: only element 0 written, no done
    mem[32'h0] = 32'd100;
    mem[32'h4] = 32'd200;
    mem[32'h8] = 32'd300;
    mem[32'h400] = 32'd0;
    mem[32'h404] = 32'd0;
    mem[32'h408] = 32'd0;
    pend = '{32'd100};
    run_job(3, 32'h400, 32'h500, 0, 1'b0, 1'b0);
    job_end = job_t0 + 7;
    wait_until(job_t0 + 7);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", done, 1'b0);
    chk("mrst_addr", bram_if.BRAM_ADDR, 32'h0);
    chk("mrst_we", bram_if.BRAM_WE, 4'h0);
    chk("mrst_wrdata", bram_if.BRAM_WRDATA, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst_elem1_unwritten", mem.exists(32'h504) ? mem[32'h504] : 32'h0, 32'h0);
    pend = '{32'd100, 32'd200, 32'd300};
    run_job(3, 32'h400, 32'h500, 0, 1'b0, 1'b1);
    wait_until(job_end);
    repeat (3) @(negedge clk);

    chk("writes_pending", 32'(wq.size()), 32'd0);
    chk("dones_pending", 32'(dq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/my_postproc.md
# my_postproc

Post-processing stage downstream of the matrix-vector PE array. After the array reports `done`, this block reads each 32-bit accumulator from the shared result BRAM. It adds a per-output bias, applies an arithmetic right shift and an optional ReLU, then writes the result back to BRAM. Software starts it with `start` and polls or interrupts on `done`.

## Interface
- `BRAM_ADDR_WIDTH`, 32, byte-address width of the BRAM port
- `BRAM_DATA_WIDTH`, 32, BRAM data width; accumulators, bias and results are signed two's complement at this width
- `BRAM_WE_WIDTH`, 4, byte-enable width
- `S_AXI_ACLK`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high; clock S_AXI_ACLK
- `start`  in  1  one-cycle pulse; sampled only in IDLE
- `num_output`  in  32  element count n, latched at start
- `bias_base`  in  32  byte address of bias[0], latched at start
- `out_base`  in  32  byte address of result[0], latched at start
- `shift`  in  5  arithmetic right-shift amount, latched at start
- `relu_en`  in  1  1 = clamp negative results to 0, latched at start
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when the job completes
- `BRAM_ADDR`  out  BRAM_ADDR_WIDTH  byte address
- `BRAM_WRDATA`  out  BRAM_DATA_WIDTH  write data
- `BRAM_WE`  out  BRAM_WE_WIDTH  byte write enables
- `BRAM_RDDATA`  in  BRAM_DATA_WIDTH  read data, valid the cycle after its address is presented

## Operation
- Accumulator k is at byte address 4k (base 0, as left by the PE array). Bias k is at bias_base+4k. Result k goes to out_base+4k. All address arithmetic wraps modulo 2^32.
- FSM states: IDLE, RD_ACC, RD_BIAS, CAP_BIAS, CALC, WR, DONE.
  - IDLE: on `start`, latch the inputs and set idx=0. Go to DONE if n==0, else to RD_ACC.
  - RD_ACC: ADDR=4·idx, WE=0. Go to RD_BIAS.
  - RD_BIAS: ADDR=bias_base+4·idx. Capture acc<=RDDATA. Go to CAP_BIAS.
  - CAP_BIAS: ADDR holds bias_base+4·idx. Capture bias<=RDDATA. Go to CALC.
  - CALC: compute the result register:
    - sum = acc+bias in 33 bits, saturated to [−2^31, 2^31−1];
    - sh = sum >>> shift (sign-extending);
    - res = (relu_en && sh<0) ? 0 : sh.
    - Go to WR.
  - WR: ADDR=out_base+4·idx, WRDATA=res, WE=4'hF. If idx==n−1 go to DONE, else idx++ and go to RD_ACC.
  - DONE: done=1. Go to IDLE.
- BRAM_ADDR, BRAM_WE and BRAM_WRDATA are decoded only from the state and datapath registers, never from inputs. Outside WR, WE=0 and WRDATA=0. In IDLE and DONE, ADDR=0.
- `start` is ignored in every state other than IDLE; no queuing.
- In-place operation (out_base=0) is legal: element k is read before it is written, and is never re-read.
- Input changes after the start cycle have no effect on the running job.

## Timing
- Reset values: busy=0, done=0, BRAM_ADDR=0, BRAM_WE=0, BRAM_WRDATA=0, state=IDLE, idx=0.
- Reset asserted mid-job:
  - the next edge returns to IDLE with every output at its reset value;
  - no `done` is produced;
  - any partially processed element is not written.
- Cycle 0 is the cycle `start` is high in IDLE.
  - Element k occupies cycles 5k+1 … 5k+5; its write (WE=4'hF) is in cycle 5k+5.
  - `done` is high in cycle 5n+1 only; busy is high in cycles 1 … 5n+1.
  - n==0: the next state is DONE, so there are no BRAM accesses, and done and busy are high in cycle 1 only.
- Exactly n writes per job, each a single cycle.
- Back-to-back jobs: a `start` in the cycle after DONE (the state is IDLE again) is accepted.
- n up to 2^32−1 is supported; idx is 32 bits.

## Test plan
- Single element, n=1, acc=100, bias=−30, shift=1, relu_en=0 -> write 35 to out_base in cycle 5; done in cycle 6 only.
- ReLU and shift, n=3, acc={−8, 7, 256}, bias={0, 0, 0}, shift=2, relu_en=1, out_base=0x100 -> writes 0, 1, 64 to 0x100, 0x104, 0x108; done in cycle 16.
- Saturation, acc=0x7FFFFFF0, bias=0x20, shift=0 -> 0x7FFFFFFF; acc=0x80000000, bias=−1 -> 0x80000000 with relu_en=0 and 0 with relu_en=1.
- In-place and back-to-back:
  - n=4, out_base=0, bias all 1, shift=0 -> each word k becomes acc_k+1, with ADDR for element k's read never following its write;
  - a second `start` the cycle after done runs the second job correctly.
- Edge cases: n=0 -> WE never asserted, done high in cycle 1; a `start` pulsed while busy -> ignored, total write count unchanged.
- Reset in cycle 7 of an n=3 job -> all outputs 0 at the next edge, no done, only element 0 written; a subsequent start completes normally.
